// File: rtl/serial_mag_comp_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
package serial_mag_comp_pkg;

  localparam int unsigned DIGIT_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    DIR_LT = 1'b0,
    DIR_GT = 1'b1
  } dir_e;

endpackage

// File: rtl/serial_mag_comp_if.sv
// Digit-serial source and result bus of serial_mag_comp; master drives digits, slave is the comparator.
interface serial_mag_comp_if;

  logic                                     start;
  logic                                     dig_valid;
  logic [serial_mag_comp_pkg::DIGIT_W-1:0]  a_dig;
  logic [serial_mag_comp_pkg::DIGIT_W-1:0]  b_dig;
  logic                                     busy;
  logic                                     done;
  logic                                     eq;
  logic                                     lt;
  logic                                     gt;

  modport master (
    output start, dig_valid, a_dig, b_dig,
    input  busy, done, eq, lt, gt
  );

  modport slave (
    input  start, dig_valid, a_dig, b_dig,
    output busy, done, eq, lt, gt
  );

endinterface

// File: rtl/serial_mag_comp_digit_cmp2.sv
// Combinational 2-bit digit comparator; exactly one of eq_o/lt_o/gt_o is high.
module digit_cmp2
  import serial_mag_comp_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  output logic               eq_o,
  output logic               lt_o,
  output logic               gt_o
);

  always_comb begin
    eq_o = (a_i == b_i);
    lt_o = (a_i <  b_i);
    gt_o = (a_i >  b_i);
  end

endmodule

// File: rtl/serial_mag_comp.sv
// Word-level magnitude comparator folding MSB-first digit results into registered eq/lt/gt.
// Optional: SERIAL_MAG_COMP_EARLY_DONE_EN finishes a word at the first differing digit.
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_mag_comp_if.slave    bus
);

  localparam int unsigned       CNT_W    = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DIGITS);

`ifdef SERIAL_MAG_COMP_EARLY_DONE_EN
  localparam bit EARLY_DONE = 1'b1;
`else
  localparam bit EARLY_DONE = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  dir_e             dir_q, dir_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;

  logic dig_eq, dig_lt, dig_gt;
  logic complete;

  digit_cmp2 u_digit_cmp2 (
    .a_i  (bus.a_dig),
    .b_i  (bus.b_dig),
    .eq_o (dig_eq),
    .lt_o (dig_lt),
    .gt_o (dig_gt)
  );

  // The word closes one cycle after its final digit was counted, giving the
  // edge-N accept / edge-N+1 done latency; no digit is taken in that cycle.
  assign complete = (state_q == RUN) &&
                    ((cnt_q == CNT_FULL) || (EARLY_DONE && decided_q));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    eq_d      = eq_q;
    lt_d      = lt_q;
    gt_d      = gt_q;

    if (bus.start) begin
      state_d   = RUN;
      cnt_d     = '0;
      decided_d = 1'b0;
      dir_d     = DIR_LT;
    end else if (state_q == RUN) begin
      if (complete) begin
        state_d = IDLE;
        done_d  = 1'b1;
        eq_d    = !decided_q;
        lt_d    = decided_q && (dir_q == DIR_LT);
        gt_d    = decided_q && (dir_q == DIR_GT);
      end else if (bus.dig_valid) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!decided_q) begin
          unique case ({dig_eq, dig_lt, dig_gt})
            3'b010: begin
              decided_d = 1'b1;
              dir_d     = DIR_LT;
            end
            3'b001: begin
              decided_d = 1'b1;
              dir_d     = DIR_GT;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      dir_q     <= DIR_LT;
      done_q    <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      gt_q      <= gt_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.eq   = eq_q;
  assign bus.lt   = lt_q;
  assign bus.gt   = gt_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Scoreboard bench for serial_mag_comp: expected results queued at start, checked on each done.
module tb_serial_mag_comp;

  localparam int unsigned DIGITS = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_mag_comp_if bus ();

  serial_mag_comp #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   dones = 0;
  int   expected_dones = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      dones++;
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("eq", {31'd0, bus.eq}, {31'd0, mon_e.eq});
        chk("lt", {31'd0, bus.lt}, {31'd0, mon_e.lt});
        chk("gt", {31'd0, bus.gt}, {31'd0, mon_e.gt});
        chk("onehot", 32'(bus.eq) + 32'(bus.lt) + 32'(bus.gt), 32'd1);
      end
    end
  end

  task automatic drive_digit(input logic [1:0] a, input logic [1:0] b);
    bus.dig_valid = 1'b1;
    bus.a_dig     = a;
    bus.b_dig     = b;
    tick();
    bus.dig_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20 && dones < expected_dones; k++) tick();
    chk("done_count", dones, expected_dones);
  endtask

  // One full word: start (optionally colliding with a bogus digit), then DIGITS digits MSB-first.
  task automatic send_word(input logic [7:0] a, input logic [7:0] b,
                           input int unsigned maxgap, input bit collide);
    res_t e;
    int unsigned gap;
    e.eq = (a == b);
    e.lt = (a < b);
    e.gt = (a > b);
    exp_q.push_back(e);
    expected_dones++;
    bus.start     = 1'b1;
    bus.dig_valid = collide;
    bus.a_dig     = 2'd3;
    bus.b_dig     = 2'd0;
    tick();
    bus.start     = 1'b0;
    bus.dig_valid = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      gap = $urandom_range(0, maxgap);
      repeat (gap) begin
`ifndef SERIAL_MAG_COMP_EARLY_DONE_EN
        chk("busy_gap", {31'd0, bus.busy}, 32'd1);
`endif
        tick();
      end
      drive_digit(a[2*i+1 -: 2], b[2*i+1 -: 2]);
    end
`ifndef SERIAL_MAG_COMP_EARLY_DONE_EN
    chk("done_edge_n", {31'd0, bus.done}, 32'd0);
    chk("busy_edge_n", {31'd0, bus.busy}, 32'd1);
    tick();
    chk("done_edge_n1", {31'd0, bus.done}, 32'd1);
    chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
`endif
    wait_done();
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.dig_valid = 1'b0;
    bus.a_dig     = '0;
    bus.b_dig     = '0;
    tick();
    tick();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_eq",   {31'd0, bus.eq},   32'd0);
    chk("rst_lt",   {31'd0, bus.lt},   32'd0);
    chk("rst_gt",   {31'd0, bus.gt},   32'd0);
    rst = 1'b0;
    tick();

    send_word(8'hA5, 8'hA5, 0, 1'b0);
    send_word(8'hA5, 8'hA4, 0, 1'b0);
    send_word(8'h40, 8'h80, 0, 1'b0);
    send_word(8'h3C, 8'h3D, 3, 1'b0);

    // Aborted word: second digit differs, then restart before it can finish.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drive_digit(2'd1, 2'd1);
    drive_digit(2'd3, 2'd0);
    send_word(8'h12, 8'h12, 0, 1'b0);

    send_word(8'h12, 8'h21, 1, 1'b1);

    // Reset mid-word after 3 digits; outputs currently hold lt from the last word.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drive_digit(2'd1, 2'd1);
    drive_digit(2'd1, 2'd1);
    drive_digit(2'd1, 2'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_eq",   {31'd0, bus.eq},   32'd0);
    chk("midrst_lt",   {31'd0, bus.lt},   32'd0);
    chk("midrst_gt",   {31'd0, bus.gt},   32'd0);
    tick();
    send_word(8'h77, 8'h76, 2, 1'b0);

    send_word(8'h80, 8'h40, 0, 1'b0);
    send_word(8'h00, 8'hFF, 0, 1'b0);
    send_word(8'hFF, 8'hFF, 1, 1'b0);

    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("done_total", dones, expected_dones);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
